// File: rtl/mux_2to1.sv
// Width-parameterized 2:1 selector with a combinational output and an
// optional one-cycle registered copy for pipelined datapath use.
module mux_2to1 #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         select,
  input  logic [n-1:0] data1,
  input  logic [n-1:0] data2,
  input  logic         en,
  output logic [n-1:0] dataOut,
  output logic [n-1:0] dataOutReg
);

  logic [n-1:0] w_sel;
  logic [n-1:0] r_out;

  // Conditional operator keeps per-bit X-merging when select is unknown.
  assign w_sel   = select ? data2 : data1;
  assign dataOut = w_sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out <= '0;
    end else if (en) begin
      r_out <= w_sel;
    end
  end

  assign dataOutReg = r_out;

endmodule

// File: tb/tb_mux_2to1.sv
// Scoreboard bench for mux_2to1: covers 32-bit and 8-bit instances,
// the combinational path, and the reset/load/hold behaviour of the register.
module tb_mux_2to1;

  logic        clk = 1'b0;
  logic        reset, select, en;
  logic [31:0] data1, data2, dataOut, dataOutReg;
  logic        b_sel, b_en;
  logic [7:0]  b_d1, b_d2, b_out, b_reg;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] q_exp[$];
  logic [31:0] sweep_exp[8] = '{32'h0, 32'h7, 32'h2, 32'h5, 32'h4, 32'h3, 32'h6, 32'h1};

  always #5 clk = ~clk;

  mux_2to1 #(.n(32)) u_dut32 (
    .clk(clk), .reset(reset), .select(select), .data1(data1), .data2(data2),
    .en(en), .dataOut(dataOut), .dataOutReg(dataOutReg)
  );

  mux_2to1 #(.n(8)) u_dut8 (
    .clk(clk), .reset(reset), .select(b_sel), .data1(b_d1), .data2(b_d2),
    .en(b_en), .dataOut(b_out), .dataOutReg(b_reg)
  );

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_pop(input string tag, input logic [31:0] obs);
    if (q_exp.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s got 0x%08h want <scoreboard empty>", tag, obs);
    end else begin
      chk_val(tag, obs, q_exp.pop_front());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; en = 1'b0; select = 1'b0; data1 = '0; data2 = '0;
    b_sel = 1'b0; b_en = 1'b0; b_d1 = '0; b_d2 = '0;
    @(posedge clk); @(posedge clk); #1;
    q_exp.push_back(32'h0); chk_pop("rst_init32", dataOutReg);
    q_exp.push_back(32'h0); chk_pop("rst_init8", {24'h0, b_reg});

    @(negedge clk);
    reset = 1'b0;
    for (int t = 0; t < 8; t++) begin
      data1 = 32'(t); data2 = 32'(8 - t); select = data1[0];
      q_exp.push_back(sweep_exp[t]);
      #1;
      chk_pop($sformatf("sweep%0d", t), dataOut);
    end

    data1 = 32'hFFFF_FFFF; data2 = 32'h0000_0000; select = 1'b0;
    q_exp.push_back(32'hFFFF_FFFF); #1; chk_pop("full_sel0", dataOut);
    select = 1'b1;
    q_exp.push_back(32'h0000_0000); #1; chk_pop("full_sel1", dataOut);

    // Load something nonzero first so the reset-over-enable check is meaningful.
    @(negedge clk);
    en = 1'b1; select = 1'b0; data1 = 32'h5555_AAAA;
    q_exp.push_back(32'h5555_AAAA);
    @(posedge clk); #1; chk_pop("preload", dataOutReg);

    @(negedge clk);
    reset = 1'b1; en = 1'b1; select = 1'b0; data1 = 32'hDEAD_BEEF;
    q_exp.push_back(32'hDEAD_BEEF); #1; chk_pop("rst_comb_pre", dataOut);
    q_exp.push_back(32'h0);
    @(posedge clk); #1; chk_pop("rst_over_en", dataOutReg);
    q_exp.push_back(32'hDEAD_BEEF); chk_pop("rst_comb_post", dataOut);

    @(negedge clk);
    reset = 1'b0; en = 1'b1; select = 1'b1; data2 = 32'h1234_5678;
    q_exp.push_back(32'h1234_5678);
    @(posedge clk); #1; chk_pop("load", dataOutReg);

    @(negedge clk);
    en = 1'b0; data2 = 32'hCAFE_F00D;
    q_exp.push_back(32'hCAFE_F00D); #1; chk_pop("hold_comb", dataOut);
    q_exp.push_back(32'h1234_5678);
    @(posedge clk); #1; chk_pop("hold_reg", dataOutReg);

    // Bits [1:0] differ between inputs and are unknown; only the agreeing bits are checked.
    @(negedge clk);
    data1 = 32'h0000_000F; data2 = 32'h0000_000C; select = 1'bx;
    q_exp.push_back(32'h0000_000C); #1; chk_pop("xsel", dataOut & 32'hFFFF_FFFC);
    select = 1'b0;

    b_d1 = 8'hA5; b_d2 = 8'h5A; b_sel = 1'b0;
    q_exp.push_back(32'hA5); #1; chk_pop("w8_sel0", {24'h0, b_out});
    b_sel = 1'b1;
    q_exp.push_back(32'h5A); #1; chk_pop("w8_sel1", {24'h0, b_out});
    @(negedge clk);
    b_en = 1'b1;
    q_exp.push_back(32'h5A);
    @(posedge clk); #1; chk_pop("w8_reg", {24'h0, b_reg});
    b_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
